traffic_phase_ctrl: RTL and testbench
=====================================

Name: traffic_phase_ctrl

Overview:
Parametrised N-way traffic-signal phase controller: one way green at a time, then amber, optional all-red clearance, then the next way. Durations are counted in enabled ticks, and the next way is chosen round-robin among ways with vehicle demand. Sits between the tick generator (1 Hz-class enable) and the lamp drivers. Replaces the fixed 4-way, 32-slot ripple-counter/decoder controller; the default parameters reproduce its 7-green/1-amber cycle.

Parameters:
NUM_WAYS, 4, number of approaches (2..16)
WAY_W, $clog2(NUM_WAYS), width of way index
CNT_W, 5, phase tick counter width; must hold max of the *_TICKS values
GREEN_TICKS, 7, enabled ticks per green phase (>=1)
YELLOW_TICKS, 1, enabled ticks per amber phase (>=1)
ALLRED_TICKS, 0, enabled ticks of all-red clearance; 0 = ALLRED state skipped
LEGACY_AMBER, 1, 1 = incoming way also shows amber during YELLOW (pre-warn); 0 = only the outgoing way shows amber

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  tick enable; phase counters advance only when en=1
demand  in  NUM_WAYS  per-way vehicle-present level
green  out  NUM_WAYS  one-hot green lamps
yellow  out  NUM_WAYS  amber lamps
red  out  NUM_WAYS  red lamps = ~green & ~yellow per way
way_idx  out  WAY_W  current owner way
next_idx  out  WAY_W  way that receives the next green (valid in YELLOW/ALLRED)
phase_end  out  1  1-cycle pulse on every phase transition

Behaviour:
- State: GREEN, YELLOW, ALLRED; registers state, way_idx, next_idx, cnt[CNT_W-1:0].
- Reset (rst_n=0 at posedge): state=GREEN, way_idx=0, next_idx=1 mod NUM_WAYS, cnt=0, phase_end=0. Hence green[0]=1 and red[1..N-1]=1 immediately after reset. Reset mid-phase aborts with no amber.
- Lamps are decoded combinationally from registered state, so there is no extra latency.
  - GREEN: green[way_idx]=1.
  - YELLOW: yellow[way_idx]=1; if LEGACY_AMBER, also yellow[next_idx]=1.
  - ALLRED: all red.
- Counting: when en=1, cnt increments. A phase ends on the en=1 cycle with cnt==TICKS-1. That cycle's posedge sets cnt=0, changes state and asserts phase_end for exactly one clk. When en=0 nothing changes.
- Transitions:
  - GREEN->YELLOW.
  - YELLOW->ALLRED, or YELLOW->GREEN(way_idx<=next_idx) if ALLRED_TICKS==0.
  - ALLRED->GREEN(way_idx<=next_idx).
- next_idx is latched on the GREEN->YELLOW transition: first way after way_idx (cyclic, wrapping N-1->0) with demand=1. If no other way has demand, next_idx=(way_idx+1) mod N, i.e. a fixed-cycle fallback, never a hold. Demand changes after the latch are ignored for that cycle.
- GREEN_TICKS=1 and YELLOW_TICKS=1 are legal. Out-of-range parameters produce an elaboration error.

Optional Feature:
TRAFFIC_PREEMPT_EN: adds ports emg_req (in, 1) and emg_way (in, WAY_W) for emergency preemption.
- In GREEN with emg_req=1 and emg_way!=way_idx: next en tick forces GREEN->YELLOW regardless of cnt, with next_idx=emg_way.
- If emg_way==way_idx: cnt is held at 0, so green persists while emg_req=1.
- In YELLOW/ALLRED: the phase completes normally, but next_idx is overwritten with emg_way.
- On emg_req release, normal counting resumes from cnt=0.
- Without the macro: no ports, no preempt logic; behaviour is exactly as above.

Decomposition:
- Package traffic_pkg: phase_e enum (GREEN, YELLOW, ALLRED), parameter-check function, rr_next function.
- Sub-module traffic_rr_pick: combinational cyclic demand picker. Inputs demand, start index; outputs index and found flag.

Test Plan:
1. Reset, default params, en=1 every clk, demand=4'b1111 -> green[0] for 7 clks; yellow[0]&yellow[1] for 1; green[1] next. Full cycle is 32 clks, and phase_end fires 8 times.
2. en asserted every 3rd clk -> green[0] lasts 21 clks; no state change on en=0 cycles.
3. demand=4'b1001 from way 0 -> sequence 0->3->0. demand=0 -> 0->1->2->3.
4. ALLRED_TICKS=2, LEGACY_AMBER=0 -> only yellow[way] is lit during amber; 2 all-red ticks precede the next green.
5. rst_n=0 during YELLOW of way 2 -> next clk green[0]=1, cnt=0, no amber.
6. TRAFFIC_PREEMPT_EN, emg_req=1 emg_way=2 at cnt=1 of way-0 green -> next tick YELLOW, then green[2] held while emg_req=1. After release, green[2] lasts 7 more ticks.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encoding, parameter legality check and round-robin helper
package traffic_pkg;
  typedef enum logic [1:0] {GREEN, YELLOW, ALLRED} phase_e;
  function automatic bit params_ok(int n, int way_w, int cnt_w, int g, int y, int a, int legacy);
    int mx;
    mx = g > y ? g : y;
    mx = a > mx ? a : mx;
    return n >= 2 && n <= 16 && way_w == $clog2(n) && cnt_w >= 1 && cnt_w <= 30 &&
           g >= 1 && y >= 1 && a >= 0 && mx <= (1 << cnt_w) && (legacy == 0 || legacy == 1);
  endfunction
  function automatic int rr_next(int cur, int n);
    return (cur + 1) % n;
  endfunction
endpackage

// File: rtl/traffic_rr_pick.sv
// traffic_rr_pick: first way after start_i (cyclic) with demand set
module traffic_rr_pick #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] demand_i,
  input  logic [WAY_W-1:0]    start_i,
  output logic [WAY_W-1:0]    idx_o,
  output logic                found_o
);
  logic [2*NUM_WAYS-1:0] dd;
  logic [NUM_WAYS-1:0] rot;
  assign dd = {demand_i, demand_i};
  assign rot = NUM_WAYS'(dd >> ({1'b0, start_i} + 1'b1));
  // rot[k-1] is the demand of way start+k; scan downwards so the nearest way wins
  always_comb begin
    idx_o = '0;
    found_o = 1'b0;
    for (int k = NUM_WAYS - 1; k >= 1; k--)
      if (rot[k-1]) begin
        idx_o = WAY_W'((int'(start_i) + k) % NUM_WAYS);
        found_o = 1'b1;
      end
  end
endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-way green/amber/all-red phase sequencer with demand round-robin.
// Define TRAFFIC_PREEMPT_EN to add emergency preemption ports emg_req/emg_way.
module traffic_phase_ctrl import traffic_pkg::*; #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W = $clog2(NUM_WAYS),
  parameter int CNT_W = 5,
  parameter int GREEN_TICKS = 7,
  parameter int YELLOW_TICKS = 1,
  parameter int ALLRED_TICKS = 0,
  parameter int LEGACY_AMBER = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NUM_WAYS-1:0] demand,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic                emg_req,
  input  logic [WAY_W-1:0]    emg_way,
`endif
  output logic [NUM_WAYS-1:0] green,
  output logic [NUM_WAYS-1:0] yellow,
  output logic [NUM_WAYS-1:0] red,
  output logic [WAY_W-1:0]    way_idx,
  output logic [WAY_W-1:0]    next_idx,
  output logic                phase_end
);
  if (!params_ok(NUM_WAYS, WAY_W, CNT_W, GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS, LEGACY_AMBER)) begin : g_param_err
    $error("traffic_phase_ctrl: illegal parameter set");
  end
  phase_e state_q, state_d;
  logic [WAY_W-1:0] way_q, way_d, next_q, next_d, pick_idx, rr_sel, green_next, nxt_eff;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim;
  logic [NUM_WAYS-1:0] way_oh, nxt_oh;
  logic pe_q, pick_found, emg_other, emg_hold, done;
  traffic_rr_pick #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_pick (
    .demand_i(demand),
    .start_i (way_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );
  // no other way waiting: advance cyclically rather than holding the green
  assign rr_sel = pick_found ? pick_idx : WAY_W'(rr_next(int'(way_q), NUM_WAYS));
`ifdef TRAFFIC_PREEMPT_EN
  assign emg_other = state_q == GREEN && emg_req && emg_way != way_q;
  assign emg_hold = state_q == GREEN && emg_req && emg_way == way_q;
  assign green_next = emg_other ? emg_way : rr_sel;
  assign nxt_eff = (emg_req && state_q != GREEN) ? emg_way : next_q;
`else
  assign emg_other = 1'b0;
  assign emg_hold = 1'b0;
  assign green_next = rr_sel;
  assign nxt_eff = next_q;
`endif
  assign lim = state_q == GREEN ? CNT_W'(GREEN_TICKS - 1) :
               state_q == YELLOW ? CNT_W'(YELLOW_TICKS - 1) : CNT_W'(ALLRED_TICKS - 1);
  assign done = en && !emg_hold && (cnt_q == lim || emg_other);
  always_comb begin
    state_d = state_q;
    way_d = way_q;
    next_d = nxt_eff;
    cnt_d = en ? ((done || emg_hold) ? '0 : cnt_q + 1'b1) : cnt_q;
    if (done && state_q == GREEN) begin
      state_d = YELLOW;
      next_d = green_next;
    end else if (done) begin
      state_d = (state_q == YELLOW && ALLRED_TICKS != 0) ? ALLRED : GREEN;
      way_d = (state_q == YELLOW && ALLRED_TICKS != 0) ? way_q : nxt_eff;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= GREEN;
      way_q <= '0;
      next_q <= WAY_W'(rr_next(0, NUM_WAYS));
      cnt_q <= '0;
      pe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      way_q <= way_d;
      next_q <= next_d;
      cnt_q <= cnt_d;
      pe_q <= done;
    end
  end
  assign way_oh = NUM_WAYS'(1) << way_q;
  assign nxt_oh = NUM_WAYS'(1) << next_q;
  assign green = state_q == GREEN ? way_oh : '0;
  assign yellow = state_q == YELLOW ? (way_oh | (LEGACY_AMBER != 0 ? nxt_oh : '0)) : '0;
  assign red = ~green & ~yellow;
  assign way_idx = way_q;
  assign next_idx = next_q;
  assign phase_end = pe_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: default instance plus an all-red/no-pre-warn instance vs. a tick-countdown model
module tb_traffic_phase_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [3:0] demand = 4'h0;
  logic [3:0] ga, ya, ra, gb, yb, rb;
  logic [1:0] wa, na, wb, nb;
  logic pa, pb;
`ifdef TRAFFIC_PREEMPT_EN
  logic emg_req = 1'b0;
  logic [1:0] emg_way = 2'd0;
`endif
  traffic_phase_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .demand(demand),
`ifdef TRAFFIC_PREEMPT_EN
    .emg_req(emg_req), .emg_way(emg_way),
`endif
    .green(ga), .yellow(ya), .red(ra), .way_idx(wa), .next_idx(na), .phase_end(pa)
  );
  traffic_phase_ctrl #(.GREEN_TICKS(3), .YELLOW_TICKS(2), .ALLRED_TICKS(2), .LEGACY_AMBER(0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .demand(demand),
`ifdef TRAFFIC_PREEMPT_EN
    .emg_req(emg_req), .emg_way(emg_way),
`endif
    .green(gb), .yellow(yb), .red(rb), .way_idx(wb), .next_idx(nb), .phase_end(pb)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, pe_cnt = 0;
  int gt[2] = '{7, 3};
  int yt[2] = '{1, 2};
  int at[2] = '{0, 2};
  int lg[2] = '{1, 0};
  int m_ph[2], m_way[2], m_nxt[2], m_left[2], m_pe[2];
  function automatic int pick(int w, logic [3:0] d);
    for (int k = 1; k < 4; k++)
      if (d[(w + k) % 4]) return (w + k) % 4;
    return (w + 1) % 4;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset(input int i);
    m_ph[i] = 0; m_way[i] = 0; m_nxt[i] = 1; m_left[i] = gt[i]; m_pe[i] = 0;
  endtask
  // phase 0=green 1=amber 2=all-red; m_left = enabled ticks still to run in this phase
  task automatic m_tick(input int i, input logic e, input logic [3:0] d);
    m_pe[i] = 0;
    if (e) begin
      m_left[i]--;
      if (m_left[i] == 0) begin
        m_pe[i] = 1;
        if (m_ph[i] == 0) begin
          m_nxt[i] = pick(m_way[i], d); m_ph[i] = 1; m_left[i] = yt[i];
        end else if (m_ph[i] == 1 && at[i] > 0) begin
          m_ph[i] = 2; m_left[i] = at[i];
        end else begin
          m_ph[i] = 0; m_way[i] = m_nxt[i]; m_left[i] = gt[i];
        end
      end
    end
  endtask
  task automatic cmp(input int i, input logic [3:0] g, y, r, input logic [1:0] w, n, input logic p);
    int eg, ey;
    eg = m_ph[i] == 0 ? 1 << m_way[i] : 0;
    ey = m_ph[i] == 1 ? ((1 << m_way[i]) | (lg[i] != 0 ? 1 << m_nxt[i] : 0)) : 0;
    chk($sformatf("dut%0d.green", i), 32'(g), eg);
    chk($sformatf("dut%0d.yellow", i), 32'(y), ey);
    chk($sformatf("dut%0d.red", i), 32'(r), ~(eg | ey) & 15);
    chk($sformatf("dut%0d.way_idx", i), 32'(w), m_way[i]);
    chk($sformatf("dut%0d.next_idx", i), 32'(n), m_nxt[i]);
    chk($sformatf("dut%0d.phase_end", i), 32'(p), m_pe[i]);
  endtask
  task automatic step(input logic r, input logic e, input logic [3:0] d);
    rst_n = r; en = e; demand = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      if (!r) m_reset(i);
      else m_tick(i, e, d);
    #1;
    cmp(0, ga, ya, ra, wa, na, pa);
    cmp(1, gb, yb, rb, wb, nb, pb);
    pe_cnt += int'(pa);
  endtask
  initial begin
    bit hit;
    step(0, 0, 4'h0);
    step(0, 1, 4'hF);
    chk("reset.green", 32'(ga), 1);
    chk("reset.red", 32'(ra), 4'hE);
    chk("reset.next", 32'(na), 1);
    pe_cnt = 0;
    for (int c = 1; c <= 32; c++) begin
      step(1, 1, 4'hF);
      if (c == 7) chk("full.amber_pair", 32'(ya), 4'h3);
      if (c == 8) chk("full.green1", 32'(ga), 4'h2);
    end
    chk("full.phase_end_count", 32'(pe_cnt), 8);
    chk("full.back_to_0", 32'(ga), 1);
    step(0, 0, 4'hF);
    for (int c = 1; c <= 21; c++) begin
      step(1, (c % 3) == 0, 4'hF);
      if (c == 20) chk("slow.green0", 32'(ga), 1);
      if (c == 21) chk("slow.amber", 32'(ya), 4'h3);
    end
    step(0, 0, 4'h9);
    for (int c = 1; c <= 16; c++) begin
      step(1, 1, 4'h9);
      if (c == 8) chk("dem1001.way3", 32'(wa), 3);
      if (c == 16) chk("dem1001.way0", 32'(wa), 0);
    end
    step(0, 0, 4'h0);
    for (int c = 1; c <= 24; c++) begin
      step(1, 1, 4'h0);
      if (c % 8 == 0) chk("dem0.fallback", 32'(wa), c / 8);
    end
    step(0, 0, 4'hF);
    for (int c = 1; c <= 7; c++) begin
      step(1, 1, 4'hF);
      if (c == 3) chk("allred.own_amber", 32'(yb), 4'h1);
      if (c == 5) chk("allred.all_red", 32'(rb), 4'hF);
      if (c == 7) chk("allred.green1", 32'(gb), 4'h2);
    end
    for (int c = 0; c < 600; c++)
      step(($urandom % 61) != 0, ($urandom % 4) != 0, 4'($urandom));
    step(0, 0, 4'hF);
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      step(1, 1, 4'hF);
      hit = m_ph[0] == 1 && m_way[0] == 2;
    end
    chk("rst_mid.reached_amber2", 32'(hit), 1);
    step(0, 1, 4'hF);
    chk("rst_mid.green0", 32'(ga), 1);
    chk("rst_mid.no_amber", 32'(ya), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
